bram1_client: RTL and testbench

Request/response front end that drives one single-ported BRAM1 instance. Accepts read/write requests on a valid/ready port, issues them to the BRAM in the cycle of acceptance, captures read data at the BRAM's fixed read latency and returns it in order through a credit-protected response FIFO. No read data is ever dropped. Sits between Bluespec-generated BRAM server methods and the BRAM1 primitive.

---
 rtl/bram1_client_fifo.sv | 77 +++++++
 rtl/bram1_client.sv | 97 +++++++++
 tb/tb_bram1_client.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram1_client_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bram1_client_fifo
// Desc     : Response FIFO with synchronous reset, any depth >= 2, and output
//            taken directly from registered storage.
// Revision : 1.0 - initial release
// ============================================================================
module bram1_client_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bram1_client.sv
`default_nettype none
// ============================================================================
// Module   : bram1_client
// Desc     : Valid/ready request front end for a single-ported BRAM1, returning
//            read data in order through a credit-protected response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module bram1_client #(
    parameter int PIPELINED  = 0,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int LAT   = 1 + PIPELINED;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic             accept;
    logic             rd_accept;
    logic             capture;
    logic             pop;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] fifo_count;
    logic [LAT-1:0]   inflight_q, inflight_d;

    // Credits count reads in flight plus queued data, so a capture always has room.
    assign req_ready = !RST && (outstanding_q < CNT_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_write;

    assign bram_en   = accept;
    assign bram_we   = accept && req_write;
    assign bram_addr = req_addr;
    assign bram_di   = req_data;

    assign capture   = inflight_q[LAT-1];
    assign rsp_valid = !RST && (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;

    generate
        if (LAT == 1) begin : g_lat_single
            assign inflight_d = rd_accept;
        end else begin : g_lat_multi
            assign inflight_d = {inflight_q[LAT-2:0], rd_accept};
        end
    endgenerate

    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_accept && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!rd_accept && pop) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            outstanding_q <= '0;
            inflight_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            inflight_q    <= inflight_d;
        end
    end

    bram1_client_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (capture),
        .data_i  (bram_do),
        .pop_i   (pop),
        .data_o  (rsp_data),
        .count_o (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_bram1_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram1_client
// Desc     : Directed self-checking bench; instance 0 is unpipelined with a
//            depth-3 FIFO, instance 1 is pipelined with a depth-4 FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram1_client;

    localparam int AW = 4;
    localparam int DW = 8;

    logic                CLK = 1'b0;
    logic [1:0]          RST;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][DW-1:0]  req_data;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [1:0][DW-1:0]  rsp_data;
    logic [1:0]          bram_en;
    logic [1:0]          bram_we;
    logic [1:0][AW-1:0]  bram_addr;
    logic [1:0][DW-1:0]  bram_di;
    logic [1:0][DW-1:0]  bram_do;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    bram1_client #(.PIPELINED(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(3)) u_dut0 (
        .CLK(CLK), .RST(RST[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .bram_en(bram_en[0]), .bram_we(bram_we[0]), .bram_addr(bram_addr[0]),
        .bram_di(bram_di[0]), .bram_do(bram_do[0])
    );

    bram1_client #(.PIPELINED(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(4)) u_dut1 (
        .CLK(CLK), .RST(RST[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .bram_en(bram_en[1]), .bram_we(bram_we[1]), .bram_addr(bram_addr[1]),
        .bram_di(bram_di[1]), .bram_do(bram_do[1])
    );

    // BRAM1 models: write-through output register, optional second stage.
    logic [DW-1:0] mem0 [16];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] do0_q, do1_q, do1_q2;

    always @(posedge CLK) begin
        if (bram_en[0]) begin
            if (bram_we[0]) begin
                mem0[bram_addr[0]] <= bram_di[0];
                do0_q <= bram_di[0];
            end else begin
                do0_q <= mem0[bram_addr[0]];
            end
        end
        if (bram_en[1]) begin
            if (bram_we[1]) begin
                mem1[bram_addr[1]] <= bram_di[1];
                do1_q <= bram_di[1];
            end else begin
                do1_q <= mem1[bram_addr[1]];
            end
        end
        do1_q2 <= do1_q;
    end

    assign bram_do = {do1_q2, do0_q};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] dat);
        req_valid[d] = v;
        req_write[d] = w;
        req_addr[d]  = a;
        req_data[d]  = dat;
    endtask

    logic [DW-1:0] exp_d;
    int            acc;
    logic [DW-1:0] stream_data [6] = '{8'hA5, 8'hB6, 8'hC7, 8'hA5, 8'hB6, 8'hC7};
    logic          ov_v [8]        = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] ov_d [8]        = '{8'h00, 8'h00, 8'h00, 8'hC7, 8'hC8, 8'h00, 8'hC9, 8'h00};

    initial begin
        RST       = 2'b11;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 2'b00;

        // Reset held with requests pending
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            for (int d = 0; d < 2; d++) begin
                check("rst_req_ready", req_ready[d], 0);
                check("rst_bram_en", bram_en[d], 0);
                check("rst_rsp_valid", rsp_valid[d], 0);
            end
        end
        @(negedge CLK);
        RST = 2'b00;
        req_valid = 2'b00;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("post_rst_ready", req_ready[d], 1);
            check("post_rst_rsp_valid", rsp_valid[d], 0);
        end

        // Instance 0: writes then a read of address 5
        @(negedge CLK); drive(0, 1, 1, 4'd5, 8'hA5); #1;
        check("wr_bram_en", bram_en[0], 1);
        check("wr_bram_we", bram_we[0], 1);
        check("wr_bram_addr", bram_addr[0], 5);
        check("wr_bram_di", bram_di[0], 8'hA5);
        @(negedge CLK); drive(0, 1, 1, 4'd6, 8'hB6);
        @(negedge CLK); drive(0, 1, 1, 4'd7, 8'hC7);
        @(negedge CLK); drive(0, 1, 0, 4'd5, 8'h00); #1;
        check("rd_bram_en", bram_en[0], 1);
        check("rd_bram_we", bram_we[0], 0);
        check("wr_no_rsp", rsp_valid[0], 0);
        @(negedge CLK); drive(0, 0, 0, 4'd0, 8'h00); #1;
        check("rd_lat_early", rsp_valid[0], 0);
        @(negedge CLK); rsp_ready[0] = 1'b1; #1;
        check("rd_lat_valid", rsp_valid[0], 1);
        check("rd_lat_data", rsp_data[0], 8'hA5);
        @(negedge CLK); #1;
        check("rd_popped", rsp_valid[0], 0);

        // Instance 0: streaming reads through a depth-3 FIFO (pointer wrap)
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            if (k < 6) drive(0, 1, 0, 4'(5 + (k % 3)), 8'h00);
            else       drive(0, 0, 0, 4'd0, 8'h00);
            #1;
            if (k < 6) check("str_ready", req_ready[0], 1);
            if (k >= 2 && k < 8) begin
                check("str_valid", rsp_valid[0], 1);
                check("str_data", rsp_data[0], stream_data[k-2]);
            end else begin
                check("str_idle", rsp_valid[0], 0);
            end
        end

        // Instance 1: fill memory with {C, addr}
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK); drive(1, 1, 1, 4'(k), {4'hC, 4'(k)}); #1;
            check("fill_ready", req_ready[1], 1);
        end
        @(negedge CLK); drive(1, 0, 0, 4'd0, 8'h00); #1;
        check("fill_no_rsp", rsp_valid[1], 0);

        // Instance 1: 16 back-to-back reads
        rsp_ready[1] = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge CLK);
            if (k < 16) drive(1, 1, 0, 4'(k), 8'h00);
            else        drive(1, 0, 0, 4'd0, 8'h00);
            #1;
            if (k < 16) check("b2b_ready", req_ready[1], 1);
            if (k >= 3 && k < 19) begin
                exp_d = {4'hC, 4'(k - 3)};
                check("b2b_valid", rsp_valid[1], 1);
                check("b2b_data", rsp_data[1], exp_d);
            end else begin
                check("b2b_idle", rsp_valid[1], 0);
            end
        end

        // Instance 1: capture+pop at occupancy 1, write after read, accept+pop
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            case (k)
                0:       drive(1, 1, 0, 4'd7, 8'h00);
                1:       drive(1, 1, 0, 4'd8, 8'h00);
                2:       drive(1, 1, 1, 4'd15, 8'hCF);
                3:       drive(1, 1, 0, 4'd9, 8'h00);
                default: drive(1, 0, 0, 4'd0, 8'h00);
            endcase
            #1;
            check("ovl_valid", rsp_valid[1], ov_v[k]);
            if (ov_v[k]) check("ovl_data", rsp_data[1], ov_d[k]);
        end

        // Instance 1: backpressure admits exactly RSP_DEPTH reads
        rsp_ready[1] = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK); drive(1, 1, 0, 4'(acc), 8'h00); #1;
            if (req_ready[1]) acc++;
        end
        check("bp_accepted", acc, 4);
        check("bp_ready_low", req_ready[1], 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK); #1;
            check("bp_hold_valid", rsp_valid[1], 1);
            check("bp_hold_data", rsp_data[1], 8'hC0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            drive(1, 0, 0, 4'd0, 8'h00);
            rsp_ready[1] = 1'b1;
            #1;
            check("bp_resume_ready", req_ready[1], (k >= 1) ? 1 : 0);
            if (k < 4) begin
                exp_d = {4'hC, 4'(k)};
                check("bp_drain_valid", rsp_valid[1], 1);
                check("bp_drain_data", rsp_data[1], exp_d);
            end else begin
                check("bp_drain_idle", rsp_valid[1], 0);
            end
        end

        // Instance 0: reset with reads queued and in flight
        rsp_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); drive(0, 1, 0, 4'(1 + k), 8'h00);
        end
        #1;
        check("mid_full", req_ready[0], 0);
        @(negedge CLK); RST[0] = 1'b1; #1;
        check("mid_rst_ready", req_ready[0], 0);
        check("mid_rst_en", bram_en[0], 0);
        check("mid_rst_valid", rsp_valid[0], 0);
        @(negedge CLK); RST[0] = 1'b0; drive(0, 0, 0, 4'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("mid_after_valid", rsp_valid[0], 0);
            check("mid_after_ready", req_ready[0], 1);
            @(negedge CLK);
        end
        rsp_ready[0] = 1'b1;
        drive(0, 1, 0, 4'd5, 8'h00); #1;
        check("mid_new_accept", bram_en[0], 1);
        @(negedge CLK); drive(0, 0, 0, 4'd0, 8'h00); #1;
        check("mid_new_early", rsp_valid[0], 0);
        @(negedge CLK); #1;
        check("mid_new_valid", rsp_valid[0], 1);
        check("mid_new_data", rsp_data[0], 8'hA5);
        @(negedge CLK); #1;
        check("mid_new_single", rsp_valid[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
